cpu6: RTL and testbench

Minimal 8-bit accumulator CPU core compatible with a working subset of the Centurion CPU6 instruction set. It sits between the system clock generator and a shared 19-bit physical memory bus that carries ROM, RAM, the MUX UART and the LED panel. It fetches and executes one instruction at a time as a multi-cycle state machine, with exactly one bus access per clock.

---
 rtl/cpu6_if.sv | 20 ++
 rtl/cpu6.sv | 201 ++++++++++++++++++++
 tb/tb_cpu6.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu6_if.sv
// Memory bus between the cpu6 core and the shared 19-bit physical memory
// (ROM, RAM, MUX UART, LED panel). The core is the master.
interface cpu6_if;
  logic [7:0]  data_in;     // read data, combinational from memory for address
  logic        int_reqn;    // interrupt request, active-low
  logic [3:0]  irq_number;  // interrupt level
  logic        write_en;    // one-cycle pulse per byte written
  logic [18:0] address;     // physical byte address
  logic [7:0]  data_out;    // write data, 0x00 when not writing

  modport master (
    input  data_in, int_reqn, irq_number,
    output write_en, address, data_out
  );

  modport slave (
    output data_in, int_reqn, irq_number,
    input  write_en, address, data_out
  );
endinterface

// File: rtl/cpu6.sv
// Minimal 8-bit accumulator core running a subset of the Centurion CPU6
// instruction set. Multi-cycle FSM with exactly one bus access per clock;
// the bus outputs are decoded combinationally from the registered state.
// Interrupt inputs are present on the bus but not acted on in this revision.
module cpu6 (
  input  logic   clock,
  input  logic   reset,
  cpu6_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_OPND1, S_OPND2, S_RD1, S_RD2, S_WR1, S_WR2, S_HALT
  } state_t;

  localparam logic [7:0] OP_HLT     = 8'h00;
  localparam logic [7:0] OP_DI      = 8'h05;
  localparam logic [7:0] OP_EI      = 8'h06;
  localparam logic [7:0] OP_BZ      = 8'h14;
  localparam logic [7:0] OP_BNZ     = 8'h15;
  localparam logic [7:0] OP_CLAW    = 8'h3A;
  localparam logic [7:0] OP_ANDB    = 8'h4A;
  localparam logic [7:0] OP_LDX_I   = 8'h60;
  localparam logic [7:0] OP_JMP     = 8'h71;
  localparam logic [7:0] OP_LDAL_I  = 8'h80;
  localparam logic [7:0] OP_LDAL_A  = 8'h81;
  localparam logic [7:0] OP_LDAL_XI = 8'h85;
  localparam logic [7:0] OP_LDAW_I  = 8'h90;
  localparam logic [7:0] OP_LDAW_A  = 8'h91;
  localparam logic [7:0] OP_STAL    = 8'hA1;
  localparam logic [7:0] OP_STAW    = 8'hB1;
  localparam logic [7:0] OP_LDBL_I  = 8'hC0;

  localparam logic [15:0] PC_RESET = 16'hFD00;

  state_t      r_state;
  logic [15:0] r_pc, r_a, r_b, r_x;
  logic [15:0] r_t;        // operand address / high byte of a 16-bit immediate
  logic [7:0]  r_op;
  logic        r_z, r_n, r_ie;

  logic [15:0] w_laddr;
  logic [7:0]  w_wdata;
  logic [15:0] w_word;
  logic [7:0]  w_and;
  logic [15:0] w_disp;
  logic        w_wr_state;

  // Top logical nibble 0xF selects the I/O and ROM window at 0x30000.
  function automatic logic [18:0] f_map(input logic [15:0] a);
    return (a[15:12] == 4'hF) ? {3'b011, a} : {3'b000, a};
  endfunction

  assign w_word     = {r_t[15:8], bus.data_in};
  assign w_and      = r_a[7:0] & r_b[7:0];
  assign w_disp     = {{8{bus.data_in[7]}}, bus.data_in};
  assign w_wr_state = (r_state == S_WR1) || (r_state == S_WR2);

  // Logical bus address and write data selected by the current state.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_laddr = r_pc;
    w_wdata = r_a[7:0];
    case (r_state)
      S_RD1:        w_laddr = (r_op == OP_LDAL_XI) ? r_x : r_t;
      S_RD2, S_WR2: w_laddr = r_t + 16'd1;
      S_WR1: begin
        w_laddr = r_t;
        if (r_op == OP_STAW) w_wdata = r_a[15:8];
      end
      default:      w_laddr = r_pc;
    endcase
  end

  // Reset overrides the bus so no write can land on the reset edge.
  assign bus.address  = reset ? f_map(PC_RESET) : f_map(w_laddr);
  assign bus.write_en = !reset && w_wr_state;
  assign bus.data_out = bus.write_en ? w_wdata : 8'h00;

  // Instruction sequencer: one bus access per state, registers updated at the
  // edge that ends the access.
  // NOTE: state registers use non-blocking assignment so every branch sees
  // pre-edge values and later assignments in the same cycle simply override.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= PC_RESET;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= '0;
      r_t     <= '0;
      r_op    <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_ie    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_op    <= bus.data_in;
          r_pc    <= r_pc + 16'd1;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_state <= S_FETCH;
          case (r_op)
            OP_HLT:  r_state <= S_HALT;
            OP_DI:   r_ie <= 1'b0;
            OP_EI:   r_ie <= 1'b1;
            OP_CLAW: begin
              r_a <= '0;
              r_z <= 1'b1;
              r_n <= 1'b0;
            end
            OP_ANDB: begin
              r_a[7:0] <= w_and;
              r_z      <= (w_and == 8'h00);
              r_n      <= w_and[7];
            end
            OP_BZ, OP_BNZ, OP_LDX_I, OP_JMP, OP_LDAL_I, OP_LDAL_A,
            OP_LDAW_I, OP_LDAW_A, OP_STAL, OP_STAW, OP_LDBL_I:
              r_state <= S_OPND1;
            OP_LDAL_XI: r_state <= S_RD1;
            default: ;  // undefined opcodes behave as NOP
          endcase
        end
        S_OPND1: begin
          r_pc    <= r_pc + 16'd1;
          r_state <= S_FETCH;
          case (r_op)
            OP_BZ:  if (r_z)  r_pc <= r_pc + 16'd1 + w_disp;
            OP_BNZ: if (!r_z) r_pc <= r_pc + 16'd1 + w_disp;
            OP_LDAL_I: begin
              r_a[7:0] <= bus.data_in;
              r_z      <= (bus.data_in == 8'h00);
              r_n      <= bus.data_in[7];
            end
            OP_LDBL_I: begin
              r_b[7:0] <= bus.data_in;
              r_z      <= (bus.data_in == 8'h00);
              r_n      <= bus.data_in[7];
            end
            default: begin
              r_t[15:8] <= bus.data_in;
              r_state   <= S_OPND2;
            end
          endcase
        end
        S_OPND2: begin
          r_pc    <= r_pc + 16'd1;
          r_state <= S_FETCH;
          case (r_op)
            OP_LDX_I: begin
              r_x <= w_word;
              r_z <= (w_word == 16'h0000);
              r_n <= w_word[15];
            end
            OP_JMP: r_pc <= w_word;
            OP_LDAW_I: begin
              r_a <= w_word;
              r_z <= (w_word == 16'h0000);
              r_n <= w_word[15];
            end
            OP_STAL, OP_STAW: begin
              r_t     <= w_word;
              r_state <= S_WR1;
            end
            default: begin
              r_t     <= w_word;
              r_state <= S_RD1;
            end
          endcase
        end
        S_RD1: begin
          r_state <= S_FETCH;
          case (r_op)
            OP_LDAL_XI, OP_LDAL_A: begin
              r_a[7:0] <= bus.data_in;
              r_z      <= (bus.data_in == 8'h00);
              r_n      <= bus.data_in[7];
              if (r_op == OP_LDAL_XI) r_x <= r_x + 16'd1;
            end
            default: begin
              r_a[15:8] <= bus.data_in;
              r_state   <= S_RD2;
            end
          endcase
        end
        S_RD2: begin
          r_a[7:0] <= bus.data_in;
          r_z      <= ({r_a[15:8], bus.data_in} == 16'h0000);
          r_n      <= r_a[15];
          r_state  <= S_FETCH;
        end
        S_WR1:   r_state <= (r_op == OP_STAW) ? S_WR2 : S_FETCH;
        S_WR2:   r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6.sv
// Self-checking bench for cpu6: an instruction-level reference model predicts
// the bus trace of every instruction, which is compared cycle by cycle.
module tb_cpu6;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cpu6_if bus ();

  cpu6 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] mem     [0:524287];   // memory seen by the DUT
  logic [7:0] ref_mem [0:524287];   // memory as the model sees it

  assign bus.data_in    = mem[bus.address];
  assign bus.int_reqn   = 1'b1;
  assign bus.irq_number = 4'h0;

  typedef struct packed {
    logic [18:0] addr;
    logic        we;
    logic [7:0]  dout;
  } cyc_t;

  cyc_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int wr_count = 0;
  int cyc_no   = 0;

  logic [15:0] m_pc, m_a, m_b, m_x;
  logic        m_z, m_n, m_ie, m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] phys(input logic [15:0] a);
    return (a[15:12] == 4'hF) ? {3'b011, a} : {3'b000, a};
  endfunction

  // ---------------- reference model ----------------
  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
    exp_q.push_back('{addr: phys(a), we: 1'b0, dout: 8'h00});
    d = ref_mem[phys(a)];
  endtask

  task automatic bus_idle(input logic [15:0] a);
    exp_q.push_back('{addr: phys(a), we: 1'b0, dout: 8'h00});
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{addr: phys(a), we: 1'b1, dout: d});
    ref_mem[phys(a)] = d;
  endtask

  task automatic flags8(input logic [7:0] v);
    m_z = (v == 8'h00);
    m_n = v[7];
  endtask

  task automatic flags16(input logic [15:0] v);
    m_z = (v == 16'h0000);
    m_n = v[15];
  endtask

  task automatic opnd8(output logic [7:0] d);
    bus_rd(m_pc, d);
    m_pc++;
  endtask

  task automatic opnd16(output logic [15:0] w);
    logic [7:0] hi, lo;
    opnd8(hi);
    opnd8(lo);
    w = {hi, lo};
  endtask

  task automatic model_reset();
    m_pc = 16'hFD00; m_a = '0; m_b = '0; m_x = '0;
    m_z = 1'b0; m_n = 1'b0; m_ie = 1'b0; m_halt = 1'b0;
  endtask

  // Execute one instruction (or one halted cycle), building its bus trace.
  task automatic model_exec();
    logic [7:0]  op, b1, b2;
    logic [15:0] w;
    exp_q.delete();
    if (m_halt) begin
      bus_idle(m_pc);
      return;
    end
    bus_rd(m_pc, op);
    m_pc++;
    bus_idle(m_pc);
    case (op)
      8'h00: m_halt = 1'b1;
      8'h05: m_ie = 1'b0;
      8'h06: m_ie = 1'b1;
      8'h14, 8'h15: begin
        opnd8(b1);
        if ((op == 8'h14) == m_z) m_pc = m_pc + {{8{b1[7]}}, b1};
      end
      8'h3A: begin m_a = '0; m_z = 1'b1; m_n = 1'b0; end
      8'h4A: begin m_a[7:0] = m_a[7:0] & m_b[7:0]; flags8(m_a[7:0]); end
      8'h60: begin opnd16(w); m_x = w; flags16(w); end
      8'h71: begin opnd16(w); m_pc = w; end
      8'h80: begin opnd8(b1); m_a[7:0] = b1; flags8(b1); end
      8'hC0: begin opnd8(b1); m_b[7:0] = b1; flags8(b1); end
      8'h81: begin opnd16(w); bus_rd(w, b1); m_a[7:0] = b1; flags8(b1); end
      8'h85: begin bus_rd(m_x, b1); m_a[7:0] = b1; m_x++; flags8(b1); end
      8'h90: begin opnd16(w); m_a = w; flags16(w); end
      8'h91: begin
        opnd16(w);
        bus_rd(w, b1);
        bus_rd(w + 16'd1, b2);
        m_a = {b1, b2};
        flags16(m_a);
      end
      8'hA1: begin opnd16(w); bus_wr(w, m_a[7:0]); end
      8'hB1: begin opnd16(w); bus_wr(w, m_a[15:8]); bus_wr(w + 16'd1, m_a[7:0]); end
      default: ;
    endcase
  endtask

  // ---------------- bench plumbing ----------------
  // Called just after a falling edge; advances to the next falling edge and
  // commits any write the DUT issued in this cycle.
  task automatic step_cycle();
    logic        pend;
    logic [18:0] wa;
    logic [7:0]  wd;
    pend = bus.write_en;
    wa   = bus.address;
    wd   = bus.data_out;
    if (pend) wr_count++;
    @(posedge clock);
    #1;
    if (pend) mem[wa] = wd;
    @(negedge clock);
    cyc_no++;
  endtask

  // Run one model instruction and compare up to lim cycles of its trace.
  task automatic run_trace(input int lim);
    model_exec();
    for (int i = 0; i < exp_q.size() && i < lim; i++) begin
      #1;
      check($sformatf("addr c%0d", cyc_no), bus.address,  exp_q[i].addr);
      check($sformatf("we c%0d",   cyc_no), bus.write_en, exp_q[i].we);
      check($sformatf("dout c%0d", cyc_no), bus.data_out, exp_q[i].dout);
      step_cycle();
    end
  endtask

  task automatic run_instr();
    run_trace(1000);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 524288; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
  endtask

  task automatic poke(input logic [18:0] pa, input logic [7:0] v);
    mem[pa]     = v;
    ref_mem[pa] = v;
  endtask

  task automatic load_rom(input logic [7:0] prog[$]);
    foreach (prog[i]) poke(19'h3FD00 + 19'(i), prog[i]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    step_cycle();
    step_cycle();
    #1;
    check("rst addr", bus.address,  19'h3FD00);
    check("rst we",   bus.write_en, 1'b0);
    check("rst dout", bus.data_out, 8'h00);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- random program generation ----------------
  logic [15:0] gen_pa;

  task automatic emit(input logic [7:0] b);
    poke(phys(gen_pa), b);
    gen_pa++;
  endtask

  task automatic emit_random_instr();
    logic [7:0]  ops [18] = '{8'h01, 8'h05, 8'h06, 8'h14, 8'h15, 8'h3A, 8'h4A, 8'h60,
                              8'h71, 8'h80, 8'h81, 8'h85, 8'h90, 8'h91, 8'hA1, 8'hB1,
                              8'hC0, 8'h77};
    logic [7:0]  op;
    logic [15:0] w;
    op = ops[$urandom_range(0, 17)];
    emit(op);
    case (op)
      8'h14, 8'h15: emit(8'($urandom_range(0, 5)));
      8'h80, 8'hC0: emit(8'($urandom));
      8'h60: begin w = 16'hB000 + 16'($urandom_range(0, 200)); emit(w[15:8]); emit(w[7:0]); end
      8'h71: begin w = 16'hFD00 + 16'($urandom_range(0, 60)); emit(w[15:8]); emit(w[7:0]); end
      8'h90: begin w = 16'($urandom); emit(w[15:8]); emit(w[7:0]); end
      8'h81, 8'h91, 8'hA1, 8'hB1: begin
        w = 16'hB000 + 16'($urandom_range(0, 254));
        emit(w[15:8]);
        emit(w[7:0]);
      end
      default: ;
    endcase
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          w0;
    logic [7:0]  exp_al [3] = '{8'h48, 8'h69, 8'h00};

    // JMP from the reset vector, then HLT with no further bus activity
    clear_mem();
    load_rom('{8'h71, 8'h80, 8'h01});
    do_reset();
    run_instr();            // JMP: 4 cycles at 3FD00..3FD02
    run_instr();            // HLT fetched at 08001 on cycle 5
    w0 = wr_count;
    repeat (4) run_instr(); // halted cycles hold at 08002
    check("halt writes", 32'(wr_count - w0), 32'd0);

    // STAL to the UART data register
    clear_mem();
    load_rom('{8'h80, 8'h41, 8'hA1, 8'hF2, 8'h01, 8'h00});
    do_reset();
    w0 = wr_count;
    repeat (4) run_instr();
    check("stal pulses", 32'(wr_count - w0), 32'd1);
    check("stal mem",    mem[19'h3F201],     8'h41);

    // STAW big-endian
    clear_mem();
    load_rom('{8'h90, 8'h12, 8'h34, 8'hB1, 8'hB0, 8'h00, 8'h00});
    do_reset();
    w0 = wr_count;
    repeat (4) run_instr();
    check("staw pulses", 32'(wr_count - w0), 32'd2);
    check("staw hi",     mem[19'h0B000],     8'h12);
    check("staw lo",     mem[19'h0B001],     8'h34);

    // BNZ not taken, then BNZ looping back to the LDAL
    clear_mem();
    load_rom('{8'h80, 8'h00, 8'h15, 8'hFE, 8'h80, 8'h01, 8'h15, 8'hFC});
    do_reset();
    repeat (10) run_instr();

    // String walk with LDAL (X)+ and BNZ
    clear_mem();
    load_rom('{8'h60, 8'hB0, 8'h00, 8'h85, 8'h15, 8'hFD, 8'h00});
    poke(19'h0B000, 8'h48);
    poke(19'h0B001, 8'h69);
    poke(19'h0B002, 8'h00);
    do_reset();
    run_instr();
    for (int k = 0; k < 3; k++) begin
      run_instr();
      check($sformatf("al seq %0d", k), dut.r_a[7:0], exp_al[k]);
      run_instr();
    end
    run_instr();
    check("str x", dut.r_x, 16'hB003);
    check("str z", dut.r_z, 1'b1);

    // Reset asserted during the first STAW write cycle
    clear_mem();
    load_rom('{8'h90, 8'h12, 8'h34, 8'hB1, 8'hB0, 8'h10, 8'h00});
    do_reset();
    run_instr();
    run_trace(4);           // STAW up to, not including, WR1
    #1;
    check("pre-rst we", bus.write_en, 1'b1);
    reset = 1'b1;
    #1;
    check("mid-rst we",   bus.write_en, 1'b0);
    check("mid-rst addr", bus.address,  19'h3FD00);
    check("mid-rst dout", bus.data_out, 8'h00);
    w0 = wr_count;
    step_cycle();
    reset = 1'b0;
    model_reset();
    check("abort writes", 32'(wr_count - w0), 32'd0);
    check("abort mem",    mem[19'h0B010],     8'h00);
    run_instr();            // refetch of LDAW at 3FD00

    // Random programs against the model
    for (int t = 0; t < 8; t++) begin
      int n;
      clear_mem();
      for (int i = 0; i < 256; i++) poke(19'h0B000 + 19'(i), 8'($urandom));
      gen_pa = 16'hFD00;
      repeat (25) emit_random_instr();
      emit(8'h00);
      do_reset();
      n = 0;
      while (!m_halt && n < 100) begin
        run_instr();
        n++;
      end
      run_instr();
      check($sformatf("rnd%0d a", t), dut.r_a, m_a);
      check($sformatf("rnd%0d b", t), dut.r_b, m_b);
      check($sformatf("rnd%0d x", t), dut.r_x, m_x);
      check($sformatf("rnd%0d z", t), dut.r_z, m_z);
      check($sformatf("rnd%0d n", t), dut.r_n, m_n);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
